// File: rtl/logic_accum_unit_if.sv
// Valid/ready bundle for logic_accum_unit: input beat channel, result channel and status.
// The unit takes the slave side. A producer/consumer or bench drives the master side.
interface logic_accum_unit_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_last;
  logic [2:0]         op;
  logic               mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_y;
  logic [COUNT_W-1:0] out_count;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, in_last, op, mode, out_ready,
    input  in_ready, out_valid, out_y, out_count, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, op, mode, out_ready,
    output in_ready, out_valid, out_y, out_count, busy
  );
endinterface

// File: rtl/logic_accum_unit.sv
// Registered bitwise logic unit with a per-beat mode and a burst-accumulate mode.
// A single output register supports backpressure and one-result-per-cycle streaming.
module logic_accum_unit #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_accum_unit_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               acceptIn;
  logic [WIDTH-1:0]   vIn;
  logic [WIDTH-1:0]   vAcc;
  logic [WIDTH-1:0]   accNew;
  logic [COUNT_W-1:0] cntNew;

  function automatic logic [WIDTH-1:0] baseOp(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0, 3'd3: r = x & y;
      3'd1, 3'd4: r = x | y;
      3'd2, 3'd5: r = x ^ y;
      default:    r = x;
    endcase
    return r;
  endfunction

  function automatic logic invertOf(input logic [2:0] sel);
    return (sel >= 3'd3) && (sel <= 3'd6);
  endfunction

  assign bus.in_ready  = (state_q != ST_OUT) | bus.out_ready;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.busy      = (state_q == ST_ACCUM);
  assign bus.out_y     = y_q;
  assign bus.out_count = count_q;

  assign acceptIn = bus.in_valid & bus.in_ready;
  assign vIn      = baseOp(bus.op, bus.in_a, bus.in_b);
  assign vAcc     = baseOp(op_q, bus.in_a, bus.in_b);
  // "Take A" ops (6/7) fold to the newest A rather than combining with the accumulator.
  assign accNew   = (op_q[2] & op_q[1]) ? vAcc : baseOp(op_q, acc_q, vAcc);
  assign cntNew   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    y_d     = y_q;
    count_d = count_q;
    case (state_q)
      ST_ACCUM: begin
        if (acceptIn) begin
          if (bus.in_last) begin
            y_d     = invertOf(op_q) ? ~accNew : accNew;
            count_d = cntNew;
            state_d = ST_OUT;
          end else begin
            acc_d = accNew;
            cnt_d = cntNew;
          end
        end
      end
      default: begin
        // IDLE and OUT share the load path so an accepted result can be replaced in the same cycle.
        if ((state_q == ST_OUT) && bus.out_ready) state_d = ST_IDLE;
        if (acceptIn) begin
          if (!bus.mode || bus.in_last) begin
            y_d     = invertOf(bus.op) ? ~vIn : vIn;
            count_d = CNT_ONE;
            state_d = ST_OUT;
          end else begin
            acc_d   = vIn;
            cnt_d   = CNT_ONE;
            op_d    = bus.op;
            state_d = ST_ACCUM;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      y_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      y_q     <= y_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_logic_accum_unit.sv
// Self-checking bench for logic_accum_unit: directed vectors plus random streams and bursts
// checked against an operator-level reference model. A COUNT_W=2 twin shadows the main unit.
module tb_logic_accum_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;

  logic_accum_unit_if #(.WIDTH(8), .COUNT_W(8)) mainIf ();
  logic_accum_unit_if #(.WIDTH(8), .COUNT_W(2)) satIf ();

  assign satIf.in_valid  = mainIf.in_valid;
  assign satIf.in_a      = mainIf.in_a;
  assign satIf.in_b      = mainIf.in_b;
  assign satIf.in_last   = mainIf.in_last;
  assign satIf.op        = mainIf.op;
  assign satIf.mode      = mainIf.mode;
  assign satIf.out_ready = mainIf.out_ready;

  logic_accum_unit #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (mainIf.slave)
  );

  logic_accum_unit #(.WIDTH(8), .COUNT_W(2)) dutSat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (satIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cnt;
  } res_t;

  res_t obsQ[$];

  // Output transfers are recorded mid-cycle; they complete on the following rising edge.
  always @(negedge clk)
    if (rst_n && mainIf.out_valid && mainIf.out_ready)
      obsQ.push_back({mainIf.out_y, mainIf.out_count});

  function automatic logic [7:0] refOp(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  // Burst result: reduce every operand of the burst with the first beat's op, then invert.
  function automatic logic [7:0] refBurst(input logic [2:0] o, input logic [7:0] aQ[$], input logic [7:0] bQ[$]);
    logic [7:0] r;
    case (o)
      3'd0, 3'd3: begin r = 8'hFF; foreach (aQ[i]) r = r & aQ[i] & bQ[i]; end
      3'd1, 3'd4: begin r = 8'h00; foreach (aQ[i]) r = r | aQ[i] | bQ[i]; end
      3'd2, 3'd5: begin r = 8'h00; foreach (aQ[i]) r = r ^ aQ[i] ^ bQ[i]; end
      default:    r = aQ[aQ.size()-1];
    endcase
    if (o >= 3'd3 && o <= 3'd6) r = ~r;
    return r;
  endfunction

  task automatic sendBeat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                          input logic m, input logic l, output bit ok);
    logic r;
    mainIf.in_valid = 1'b1;
    mainIf.in_a     = a;
    mainIf.in_b     = b;
    mainIf.op       = o;
    mainIf.mode     = m;
    mainIf.in_last  = l;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r = mainIf.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    mainIf.in_valid = 1'b0;
  endtask

  task automatic waitResults(input int n, output bit ok);
    for (int i = 0; i < 300 && obsQ.size() < n; i++) begin
      @(posedge clk);
      #1;
    end
    ok = (obsQ.size() >= n);
  endtask

  task automatic test_reset();
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mainIf.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", mainIf.out_valid); end
    checks++; if (mainIf.out_y !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_y: got %h expected 00", mainIf.out_y); end
    checks++; if (mainIf.out_count !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_count: got %0d expected 0", mainIf.out_count); end
    checks++; if (mainIf.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", mainIf.busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (mainIf.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready: got %b expected 1", mainIf.in_ready); end
    mainIf.out_ready = 1'b0;
    sendBeat(8'hC5, 8'h3A, 3'd1, 1'b0, 1'b0, ok);
    checks++; if (!ok || mainIf.out_valid !== 1'b1 || mainIf.out_y !== 8'hFF) begin failures++; $display("[TB] FAIL pre_reset_load: got valid=%b y=%h expected valid=1 y=FF", mainIf.out_valid, mainIf.out_y); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mainIf.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midop_reset_valid: got %b expected 0", mainIf.out_valid); end
    checks++; if (mainIf.out_y !== 8'h00 || mainIf.out_count !== 8'h00) begin failures++; $display("[TB] FAIL midop_reset_data: got y=%h cnt=%0d expected y=00 cnt=0", mainIf.out_y, mainIf.out_count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    obsQ.delete();
  endtask

  task automatic test_per_beat_ops();
    bit ok;
    logic [7:0] expTab [8];
    expTab = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h3A, 8'hC5};
    mainIf.out_ready = 1'b1;
    for (int o = 0; o < 8; o++) begin
      sendBeat(8'hC5, 8'h3A, 3'(o), 1'b0, 1'b0, ok);
      checks++; if (!ok || mainIf.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL per_beat_valid op=%0d: got %b expected 1", o, mainIf.out_valid); end
      checks++; if (mainIf.out_y !== expTab[o]) begin failures++; $display("[TB] FAIL per_beat_y op=%0d: got %h expected %h", o, mainIf.out_y, expTab[o]); end
      checks++; if (mainIf.out_count !== 8'd1) begin failures++; $display("[TB] FAIL per_beat_count op=%0d: got %0d expected 1", o, mainIf.out_count); end
    end
    @(posedge clk);
    #1 obsQ.delete();
  endtask

  task automatic test_accumulate();
    bit ok;
    logic [7:0] aV [3];
    logic [7:0] bV [3];
    logic [7:0] expY [2];
    logic [2:0] ops [2];
    aV = '{8'hF0, 8'hFF, 8'hF5};
    bV = '{8'hFF, 8'h3C, 8'hFF};
    expY = '{8'h30, 8'hCF};
    ops = '{3'd0, 3'd3};
    mainIf.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        sendBeat(aV[i], bV[i], ops[k], 1'b1, i == 2, ok);
        if (i < 2) begin
          checks++; if (!ok || mainIf.busy !== 1'b1) begin failures++; $display("[TB] FAIL accum_busy beat=%0d: got %b expected 1", i + 1, mainIf.busy); end
        end
      end
      checks++; if (mainIf.out_valid !== 1'b1 || mainIf.busy !== 1'b0) begin failures++; $display("[TB] FAIL accum_done op=%0d: got valid=%b busy=%b expected 1/0", ops[k], mainIf.out_valid, mainIf.busy); end
      checks++; if (mainIf.out_y !== expY[k] || mainIf.out_count !== 8'd3) begin failures++; $display("[TB] FAIL accum_result op=%0d: got y=%h cnt=%0d expected y=%h cnt=3", ops[k], mainIf.out_y, mainIf.out_count, expY[k]); end
    end
    // Random bursts with op changing after the first beat; only the first op counts.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] aQ[$];
      logic [7:0] bQ[$];
      logic [2:0] op0;
      logic [7:0] ey;
      int len;
      int sat;
      bit allOk;
      allOk = 1'b1;
      len = $urandom_range(1, 5);
      op0 = 3'($urandom_range(0, 7));
      for (int i = 0; i < len; i++) begin
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = 8'($urandom);
        aQ.push_back(a);
        bQ.push_back(b);
        sendBeat(a, b, (i == 0) ? op0 : 3'($urandom_range(0, 7)), 1'b1, i == len - 1, ok);
        allOk &= ok;
      end
      ey = refBurst(op0, aQ, bQ);
      sat = (len > 3) ? 3 : len;
      checks++; if (!allOk || mainIf.out_valid !== 1'b1 || mainIf.out_y !== ey) begin failures++; $display("[TB] FAIL rand_burst_y op=%0d len=%0d: got %h expected %h", op0, len, mainIf.out_y, ey); end
      checks++; if (mainIf.out_count !== 8'(len) || satIf.out_count !== 2'(sat)) begin failures++; $display("[TB] FAIL rand_burst_cnt len=%0d: got %0d/%0d expected %0d/%0d", len, mainIf.out_count, satIf.out_count, len, sat); end
    end
    @(posedge clk);
    #1 obsQ.delete();
  endtask

  task automatic test_op_change();
    bit ok;
    mainIf.out_ready = 1'b1;
    sendBeat(8'h01, 8'h02, 3'd1, 1'b1, 1'b0, ok);
    sendBeat(8'h04, 8'h00, 3'd2, 1'b1, 1'b0, ok);
    sendBeat(8'h10, 8'h00, 3'd2, 1'b1, 1'b1, ok);
    checks++; if (!ok || mainIf.out_y !== 8'h17 || mainIf.out_count !== 8'd3) begin failures++; $display("[TB] FAIL op_change: got y=%h cnt=%0d expected y=17 cnt=3", mainIf.out_y, mainIf.out_count); end
    @(posedge clk);
    #1 obsQ.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit allOk;
    bit done;
    logic [7:0] expQ[$];
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] o;
    allOk = 1'b1;
    done = 1'b0;
    obsQ.delete();
    mainIf.out_ready = 1'b0;
    a = 8'($urandom); b = 8'($urandom); o = 3'($urandom_range(0, 7));
    sendBeat(a, b, o, 1'b0, 1'b0, ok);
    allOk &= ok;
    expQ.push_back(refOp(o, a, b));
    a = 8'($urandom); b = 8'($urandom); o = 3'($urandom_range(0, 7));
    mainIf.in_valid = 1'b1; mainIf.in_a = a; mainIf.in_b = b; mainIf.op = o; mainIf.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (mainIf.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready cyc=%0d: got %b expected 0", i, mainIf.in_ready); end
      checks++; if (mainIf.out_valid !== 1'b1 || mainIf.out_y !== expQ[0]) begin failures++; $display("[TB] FAIL stall_hold cyc=%0d: got valid=%b y=%h expected 1/%h", i, mainIf.out_valid, mainIf.out_y, expQ[0]); end
      @(posedge clk);
      #1;
    end
    mainIf.out_ready = 1'b1;
    sendBeat(a, b, o, 1'b0, 1'b1, ok);
    allOk &= ok;
    expQ.push_back(refOp(o, a, b));
    checks++; if (mainIf.out_valid !== 1'b1 || mainIf.out_y !== expQ[1]) begin failures++; $display("[TB] FAIL same_cycle_reload: got valid=%b y=%h expected 1/%h", mainIf.out_valid, mainIf.out_y, expQ[1]); end
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          a = 8'($urandom); b = 8'($urandom); o = 3'($urandom_range(0, 7));
          sendBeat(a, b, o, 1'b0, 1'($urandom), ok);
          allOk &= ok;
          expQ.push_back(refOp(o, a, b));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 mainIf.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    mainIf.out_ready = 1'b1;
    waitResults(22, ok);
    checks++; if (!allOk || !ok || obsQ.size() != 22) begin failures++; $display("[TB] FAIL stream_count: got %0d results expected 22", obsQ.size()); end
    for (int i = 0; i < 22 && i < obsQ.size(); i++) begin
      checks++; if (obsQ[i].y !== expQ[i] || obsQ[i].cnt !== 8'd1) begin failures++; $display("[TB] FAIL stream_item %0d: got y=%h cnt=%0d expected y=%h cnt=1", i, obsQ[i].y, obsQ[i].cnt, expQ[i]); end
    end
    obsQ.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit allOk;
    int c0;
    logic [7:0] expQ[$];
    allOk = 1'b1;
    obsQ.delete();
    mainIf.out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] o;
      a = 8'($urandom); b = 8'($urandom); o = 3'($urandom_range(0, 7));
      sendBeat(a, b, o, 1'b0, 1'b0, ok);
      allOk &= ok;
      expQ.push_back(refOp(o, a, b));
    end
    checks++; if (!allOk || cyc - c0 != 6) begin failures++; $display("[TB] FAIL b2b_throughput: got %0d cycles expected 6", cyc - c0); end
    waitResults(6, ok);
    for (int i = 0; i < 6; i++) begin
      checks++; if (!ok || obsQ[i].y !== expQ[i]) begin failures++; $display("[TB] FAIL b2b_item %0d: got %h expected %h", i, ok ? obsQ[i].y : 8'hxx, expQ[i]); end
    end
    obsQ.delete();
  endtask

  task automatic test_saturation();
    bit ok;
    bit allOk;
    int lens [2];
    logic [2:0] ops [2];
    lens = '{5, 3};
    ops = '{3'd2, 3'd5};
    mainIf.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] aQ[$];
      logic [7:0] bQ[$];
      logic [7:0] ey;
      allOk = 1'b1;
      for (int i = 0; i < lens[k]; i++) begin
        aQ.push_back(8'($urandom));
        bQ.push_back(8'($urandom));
        sendBeat(aQ[i], bQ[i], ops[k], 1'b1, i == lens[k] - 1, ok);
        allOk &= ok;
      end
      ey = refBurst(ops[k], aQ, bQ);
      checks++; if (!allOk || mainIf.out_y !== ey || satIf.out_y !== ey) begin failures++; $display("[TB] FAIL sat_y len=%0d: got %h/%h expected %h", lens[k], mainIf.out_y, satIf.out_y, ey); end
      checks++; if (satIf.out_count !== 2'd3 || mainIf.out_count !== 8'(lens[k])) begin failures++; $display("[TB] FAIL sat_count len=%0d: got %0d/%0d expected 3/%0d", lens[k], satIf.out_count, mainIf.out_count, lens[k]); end
    end
    @(posedge clk);
    #1 obsQ.delete();
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit allOk;
    logic [7:0] aQ[$];
    logic [7:0] bQ[$];
    logic [7:0] ey;
    allOk = 1'b1;
    mainIf.out_ready = 1'b1;
    sendBeat(8'h0F, 8'h30, 3'd1, 1'b1, 1'b0, ok);
    sendBeat(8'h40, 8'h00, 3'd1, 1'b1, 1'b0, ok);
    checks++; if (!ok || mainIf.busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before: got %b expected 1", mainIf.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mainIf.busy !== 1'b0 || mainIf.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_reset: got busy=%b valid=%b expected 0/0", mainIf.busy, mainIf.out_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    obsQ.delete();
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (obsQ.size() != 0 || mainIf.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_output: got %0d results valid=%b expected 0/0", obsQ.size(), mainIf.out_valid); end
    for (int i = 0; i < 3; i++) begin
      aQ.push_back(8'($urandom));
      bQ.push_back(8'($urandom));
      sendBeat(aQ[i], bQ[i], 3'd0, 1'b1, i == 2, ok);
      allOk &= ok;
    end
    ey = refBurst(3'd0, aQ, bQ);
    checks++; if (!allOk || mainIf.out_y !== ey || mainIf.out_count !== 8'd3) begin failures++; $display("[TB] FAIL abort_next_burst: got y=%h cnt=%0d expected y=%h cnt=3", mainIf.out_y, mainIf.out_count, ey); end
    @(posedge clk);
    #1 obsQ.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst_n = 1'b0;
    mainIf.in_valid = 1'b0;
    mainIf.in_a = '0;
    mainIf.in_b = '0;
    mainIf.in_last = 1'b0;
    mainIf.op = '0;
    mainIf.mode = 1'b0;
    mainIf.out_ready = 1'b0;
    test_reset();
    test_per_beat_ops();
    test_accumulate();
    test_op_change();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/logic_accum_unit.md
Name: logic_accum_unit

Overview:
- Parametrised, registered successor to the lab's single-bit two-input gates.
- Applies one of eight bitwise logic operations to WIDTH-bit operand pairs.
- Per-beat mode: one result per beat. Accumulate mode: reduces a multi-beat burst into one result.
- Sits between a valid/ready producer and consumer; single output register with backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits.
- COUNT_W, 8, width of the beat counter reported with each result.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_last  input  1  final beat of burst; accumulate mode only.
- op  input  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A, 7 PASS A.
- mode  input  1  0 = per-beat, 1 = accumulate.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_y  output  WIDTH  result.
- out_count  output  COUNT_W  beats folded into this result.
- busy  output  1  burst in progress (state ACCUM).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; out_y=0; out_count=0; busy=0; accumulator=0.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-burst discards the partial result. No output is produced for that burst.
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready (both sampled at clk rise).
- in_ready = (state!=OUT) | out_ready. Combinational; no combinational path from in_valid.
- Base op and invert flag:
  - op 0/3 use base AND; op 1/4 use base OR; op 2/5 use base XOR.
  - op 6/7 use base "take A".
  - op 3, 4, 5, 6 set invert; the rest do not.
- Per-beat value: v = base(in_a, in_b).
- Operation latching:
  - op and mode are captured on the first beat of a transfer or burst.
  - Changes to op or mode while in ACCUM are ignored until the burst ends.
- States:
  - IDLE: accept beat.
    - mode=0, or mode=1 with in_last=1: load out_y = invert ? ~v : v; out_count=1; go OUT.
    - mode=1 with in_last=0: acc=v; cnt=1; go ACCUM.
  - ACCUM: busy=1. On accept: acc = base(acc, v), where "take A" gives acc=in_a; cnt=cnt+1.
    - If in_last=1: out_y = invert ? ~acc_new : acc_new; out_count=cnt_new; go OUT.
  - OUT: out_valid=1; out_y and out_count held stable until accepted.
    - On accept with no simultaneous input beat: go IDLE.
    - Simultaneous output accept and input accept: handle the input exactly as in IDLE in the same cycle. This gives back-to-back throughput of one result per cycle in per-beat mode.
- Latency: 1 cycle from acceptance of the final beat to out_valid=1.
- Counter: cnt saturates at 2^COUNT_W-1; the burst continues and is reduced normally.
- in_last is ignored in mode=0.
- No beat is dropped or duplicated under any in_valid/out_ready pattern.

Test Plan:
- Reset and idle:
  - Assert rst_n=0 mid-operation -> out_valid=0, out_y=0, out_count=0, busy=0 immediately.
  - Release rst_n -> in_ready=1.
- Per-beat all ops: a=8'hC5, b=8'h3A, op 0..7, out_ready=1 -> out_y = 00, FF, FF, FF, 00, 00, 3A, C5; out_count=1; each result one cycle after accept.
- Accumulate AND, mode=1, op=0, 3 beats:
  - (F0,FF), (FF,3C), (F5,FF) with last on beat 3.
  - Result: out_y=8'h30, out_count=3, busy=1 during beats 2-3.
  - Same burst with op=3 -> out_y=8'hCF.
- Backpressure:
  - Per-beat stream with out_ready=0 for 4 cycles -> in_ready=0, out_y held.
  - out_ready=1 with in_valid=1 -> next result loaded in the same cycle; no loss or duplication over 20 random beats vs model.
- Mid-burst op change: burst begins op=1 (OR); op switched to 2 on beat 2.
  - Beats (01,02), (04,00), (10,00)+last -> out_y=8'h17 (OR retained).
- Saturation and reset abort:
  - COUNT_W=2, 5-beat XOR burst -> out_count=3 and correct XOR result.
  - rst_n pulse in ACCUM -> no out_valid; next burst starts clean.
